i2c_master_ctrl: RTL and testbench

- Single-transaction I2C master that drives the SCL/SDA bus feeding the team's I2C slave (7-bit device address, 8-bit internal memory pointer, one data byte per transaction).
- Accepts a command from a local host (start pulse plus device address, R/W, memory address and write data) and runs the full framing sequence.
- Frame: START, address+R/W, ACK, pointer, ACK, data byte with ACK (write) or master-NACK (read), STOP.
- Returns read data, a done pulse and an ACK-error flag.

---
 rtl/i2c_master_ctrl.sv | 172 +++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C master: START, {addr,R/W}, pointer, one data byte, STOP.
// SCL is push-pull; SDA is open-drain and follows SCL by one clk to give hold margin.
module i2c_master_ctrl #(
   parameter int QDIV   = 63,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] dev_addr,
   input  logic              rw,
   input  logic [7:0]        mem_addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata,
   output logic              busy,
   output logic              done,
   output logic              ack_err,
   output logic              scl,
   inout  wire               sda
);
   localparam int QW = $clog2(QDIV);
   localparam logic [QW-1:0] QMAX = QW'(QDIV - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ACK1, S_REG, S_ACK2,
      S_WDATA, S_ACK3, S_RDATA, S_MNACK, S_STOP, S_DONE
   } state_t;

   state_t            r_state, w_state_nx;
   logic [QW-1:0]     r_qcnt;
   logic [1:0]        r_q;
   logic [2:0]        r_bit;
   logic [ADDR_W-1:0] r_dev;
   logic              r_rw;
   logic [7:0]        r_mem, r_wdata, r_rx, r_rdata;
   logic              r_busy, r_done, r_ack_err, r_nack;
   logic              r_scl, r_sda_d, r_sda_lo;
   logic              w_in_frame, w_qtick, w_sample, w_phase_end, w_last_bit;
   logic              w_scl_nx, w_sda_lo_nx, w_tx_bit, w_sda_in, w_is_ack;
   logic [7:0]        w_tx_byte;

   assign w_sda_in   = sda;
   assign w_in_frame = (r_state != S_IDLE) && (r_state != S_DONE);
   assign w_qtick    = w_in_frame && (r_qcnt == QMAX);
   assign w_sample   = w_qtick && (r_q == 2'd2);
   assign w_last_bit = (r_bit == 3'd0);
   assign w_tx_bit   = w_tx_byte[r_bit];
   assign w_is_ack   = (r_state == S_ACK1) || (r_state == S_ACK2) || (r_state == S_ACK3);

   // Next state, phase end and bus level decode for the current quarter
   always_comb begin
      w_state_nx  = r_state;
      w_phase_end = 1'b0;
      w_tx_byte   = 8'hFF;
      w_scl_nx    = 1'b1;
      w_sda_lo_nx = 1'b0;
      case (r_state)
         S_START:        w_phase_end = w_qtick && (r_q == 2'd1);
         S_STOP:         w_phase_end = w_qtick && (r_q == 2'd2);
         S_IDLE, S_DONE: w_phase_end = 1'b0;
         default:        w_phase_end = w_qtick && (r_q == 2'd3);
      endcase
      case (r_state)
         S_ADDR:  w_tx_byte = {r_dev, r_rw};
         S_REG:   w_tx_byte = r_mem;
         S_WDATA: w_tx_byte = r_wdata;
         default: w_tx_byte = 8'hFF;
      endcase
      case (r_state)
         S_IDLE:  if (start) w_state_nx = S_START;
         S_START: if (w_phase_end) w_state_nx = S_ADDR;
         S_ADDR:  if (w_phase_end && w_last_bit) w_state_nx = S_ACK1;
         S_ACK1:  if (w_phase_end) w_state_nx = S_REG;
         S_REG:   if (w_phase_end && w_last_bit) w_state_nx = S_ACK2;
         S_ACK2:  if (w_phase_end) w_state_nx = r_rw ? S_RDATA : S_WDATA;
         S_WDATA: if (w_phase_end && w_last_bit) w_state_nx = S_ACK3;
         S_RDATA: if (w_phase_end && w_last_bit) w_state_nx = S_MNACK;
         S_ACK3, S_MNACK: if (w_phase_end) w_state_nx = S_STOP;
         S_STOP:  if (w_phase_end) w_state_nx = S_DONE;
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
      case (r_state)
         S_START: begin
            w_scl_nx    = (r_q == 2'd0);
            w_sda_lo_nx = 1'b1;
         end
         S_ADDR, S_REG, S_WDATA: begin
            w_scl_nx    = r_q[1];
            w_sda_lo_nx = ~w_tx_bit;
         end
         S_ACK1, S_ACK2, S_ACK3, S_RDATA, S_MNACK: begin
            w_scl_nx    = r_q[1];
            w_sda_lo_nx = 1'b0;
         end
         S_STOP: begin
            w_scl_nx    = (r_q != 2'd0);
            w_sda_lo_nx = (r_q != 2'd2);
         end
         default: begin
            w_scl_nx    = 1'b1;
            w_sda_lo_nx = 1'b0;
         end
      endcase
   end

   // State register with quarter and bit counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_qcnt  <= '0;
         r_q     <= 2'd0;
         r_bit   <= 3'd0;
      end else begin
         r_state <= w_state_nx;
         if (!w_in_frame || w_qtick) r_qcnt <= '0;
         else r_qcnt <= r_qcnt + QW'(1);
         if (w_phase_end) r_q <= 2'd0;
         else if (w_qtick) r_q <= r_q + 2'd1;
         if (w_state_nx != r_state) r_bit <= 3'd7;
         else if (w_phase_end) r_bit <= r_bit - 3'd1;
      end
   end

   // Command capture, ACK/NACK tracking, receive shifter and status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dev <= '0; r_rw <= 1'b0; r_mem <= 8'h00; r_wdata <= 8'h00;
         r_rx <= 8'h00; r_rdata <= 8'h00; r_busy <= 1'b0; r_done <= 1'b0;
         r_ack_err <= 1'b0; r_nack <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_dev     <= dev_addr;
            r_rw      <= rw;
            r_mem     <= mem_addr;
            r_wdata   <= wdata;
            r_busy    <= 1'b1;
            r_ack_err <= 1'b0;
            r_nack    <= 1'b0;
         end else if (r_state == S_DONE) begin
            r_busy <= 1'b0;
         end
         // a NACK is only remembered here; the frame still runs through STOP
         if (w_sample && w_is_ack && w_sda_in) r_nack <= 1'b1;
         if (w_sample && (r_state == S_RDATA)) r_rx <= {r_rx[6:0], w_sda_in};
         if (w_phase_end && (r_state == S_MNACK)) r_rdata <= r_rx;
         r_done <= (r_state == S_STOP) && (w_state_nx == S_DONE);
         if ((r_state == S_STOP) && (w_state_nx == S_DONE)) r_ack_err <= r_nack;
      end
   end

   // Registered bus drivers; SDA takes one extra stage so it moves after SCL falls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scl    <= 1'b1;
         r_sda_d  <= 1'b0;
         r_sda_lo <= 1'b0;
      end else begin
         r_scl    <= w_scl_nx;
         r_sda_d  <= w_sda_lo_nx;
         r_sda_lo <= r_sda_d;
      end
   end

   assign sda     = r_sda_lo ? 1'b0 : 1'bz;
   assign scl     = r_scl;
   assign rdata   = r_rdata;
   assign busy    = r_busy;
   assign done    = r_done;
   assign ack_err = r_ack_err;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: bus-level slave model at 0x66 plus timing monitor.
module tb_i2c_master_ctrl;
   localparam int QDIV = 4;
   localparam int FRAME_BUSY = 113 * QDIV + 1;
   localparam logic [6:0] SLV = 7'h66;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] dev_addr = 7'h00;
   logic [7:0] mem_addr = 8'h00;
   logic [7:0] wdata = 8'h00;
   logic [7:0] rdata;
   logic       busy, done, ack_err, scl;
   wire        sda;
   logic       slv_drv = 1'b0;

   pullup (sda);
   assign sda = (slv_drv && !rst) ? 1'b0 : 1'bz;

   i2c_master_ctrl #(.QDIV(QDIV), .ADDR_W(7)) dut (
      .clk(clk), .rst(rst), .start(start), .dev_addr(dev_addr), .rw(rw),
      .mem_addr(mem_addr), .wdata(wdata), .rdata(rdata), .busy(busy),
      .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] mem [256];
   logic [7:0] bus_bytes [4];
   logic       ack_bits [4];
   logic [7:0] sh = 8'h00, ptr = 8'h00, tx = 8'h00;
   logic       addressed = 1'b0, rdmode = 1'b0;
   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   int         bitn = 0, byten = 0, since_edge = 0;
   int         hi8 = 0, lo8 = 0, n_start = 0, n_stop = 0, n_done = 0, busy_cyc = 0;
   logic [7:0] rd_at_done = 8'h00;
   logic       ae_at_done = 1'b0;

   // Slave model and bus monitor, sampled on the falling clk edge
   always @(negedge clk) begin
      if (rst) begin
         bitn <= 0; byten <= 0; slv_drv <= 1'b0; addressed <= 1'b0;
         since_edge <= 0; prev_scl <= scl; prev_sda <= sda;
      end else begin
         since_edge <= (scl != prev_scl) ? 0 : since_edge + 1;
         prev_scl   <= scl;
         prev_sda   <= sda;
         if (busy) busy_cyc <= busy_cyc + 1;
         if (done) begin
            n_done <= n_done + 1; rd_at_done <= rdata; ae_at_done <= ack_err;
         end
         if (prev_scl && scl && prev_sda && !sda) begin
            n_start <= n_start + 1; bitn <= 0; byten <= 0; slv_drv <= 1'b0;
            addressed <= 1'b0; hi8 <= 0; lo8 <= 0;
         end else if (prev_scl && scl && !prev_sda && sda) begin
            n_stop <= n_stop + 1;
         end else if (!prev_scl && scl) begin
            if (since_edge + 1 == 2 * QDIV) lo8 <= lo8 + 1;
            if (bitn < 8) begin
               sh <= {sh[6:0], sda};
               bitn <= bitn + 1;
               if (bitn == 7) bus_bytes[byten] <= {sh[6:0], sda};
            end else if (bitn == 8) begin
               ack_bits[byten] <= sda;
               bitn <= 9;
            end
         end else if (prev_scl && !scl) begin
            if (since_edge + 1 == 2 * QDIV) hi8 <= hi8 + 1;
            if (bitn == 8) begin
               case (byten)
                  0: begin
                     addressed <= (sh[7:1] == SLV); rdmode <= sh[0]; slv_drv <= (sh[7:1] == SLV);
                  end
                  1: begin ptr <= sh; slv_drv <= addressed; end
                  2: begin
                     if (!rdmode && addressed) begin mem[ptr] <= sh; slv_drv <= 1'b1; end
                     else slv_drv <= 1'b0;
                  end
                  default: slv_drv <= 1'b0;
               endcase
            end else if (bitn == 9) begin
               bitn <= 0; byten <= byten + 1;
               if (byten == 1 && addressed && rdmode) begin
                  tx <= mem[ptr]; slv_drv <= !mem[ptr][7];
               end else slv_drv <= 1'b0;
            end else if (bitn >= 1 && bitn <= 7 && byten == 2 && addressed && rdmode) begin
               slv_drv <= !tx[7 - bitn];
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] m, input logic [7:0] d);
      dev_addr = a; rw = r; mem_addr = m; wdata = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int base, input string tag);
      int k = 0;
      while (n_done == base && k < 2000) begin
         @(negedge clk);
         k++;
      end
      repeat (4) @(negedge clk);
      check({tag, "_done_count"}, n_done - base, 1);
   endtask

   int s0, p0, d0, b0;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_scl", scl, 1);
      check("rst_sda", sda, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ack_err", ack_err, 0);
      check("rst_rdata", rdata, 8'h00);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // write 0xA5 to slave 0x66 pointer 0x10
      s0 = n_start; p0 = n_stop; d0 = n_done; b0 = busy_cyc;
      issue(7'h66, 1'b0, 8'h10, 8'hA5);
      wait_done(d0, "wr");
      check("wr_byte0", bus_bytes[0], 8'hCC);
      check("wr_byte1", bus_bytes[1], 8'h10);
      check("wr_byte2", bus_bytes[2], 8'hA5);
      check("wr_acks", {ack_bits[0], ack_bits[1], ack_bits[2]}, 3'b000);
      check("wr_starts", n_start - s0, 1);
      check("wr_stops", n_stop - p0, 1);
      check("wr_ack_err", ae_at_done, 0);
      check("wr_mem", mem[8'h10], 8'hA5);
      check("wr_busy_len", busy_cyc - b0, FRAME_BUSY);
      check("wr_scl_high8", hi8, 27);
      check("wr_scl_low8", lo8, 26);
      check("wr_busy_after", busy, 0);

      // read it back
      d0 = n_done; p0 = n_stop;
      issue(7'h66, 1'b1, 8'h10, 8'h00);
      wait_done(d0, "rd");
      check("rd_byte0", bus_bytes[0], 8'hCD);
      check("rd_byte1", bus_bytes[1], 8'h10);
      check("rd_bus_data", bus_bytes[2], 8'hA5);
      check("rd_acks", {ack_bits[0], ack_bits[1]}, 2'b00);
      check("rd_master_nack", ack_bits[2], 1);
      check("rd_rdata", rd_at_done, 8'hA5);
      check("rd_ack_err", ae_at_done, 0);
      check("rd_stops", n_stop - p0, 1);

      // no slave at 0x12
      d0 = n_done; p0 = n_stop; b0 = busy_cyc;
      issue(7'h12, 1'b0, 8'h10, 8'h5A);
      wait_done(d0, "na");
      check("na_ack_err", ae_at_done, 1);
      check("na_byte0", bus_bytes[0], 8'h24);
      check("na_byte2", bus_bytes[2], 8'h5A);
      check("na_acks", {ack_bits[0], ack_bits[1], ack_bits[2]}, 3'b111);
      check("na_stops", n_stop - p0, 1);
      check("na_busy_len", busy_cyc - b0, FRAME_BUSY);
      check("na_rdata_hold", rdata, 8'hA5);
      check("na_mem_kept", mem[8'h10], 8'hA5);
      repeat (20) @(negedge clk);
      check("na_ack_err_held", ack_err, 1);

      // second start during ADDR must be ignored
      d0 = n_done;
      issue(7'h66, 1'b0, 8'h20, 8'h3C);
      repeat (30) @(negedge clk);
      check("bg_ack_err_cleared", ack_err, 0);
      issue(7'h12, 1'b1, 8'h30, 8'hFF);
      wait_done(d0, "bg");
      repeat (500) @(negedge clk);
      check("bg_single_done", n_done - d0, 1);
      check("bg_byte0", bus_bytes[0], 8'hCC);
      check("bg_byte1", bus_bytes[1], 8'h20);
      check("bg_byte2", bus_bytes[2], 8'h3C);
      check("bg_mem", mem[8'h20], 8'h3C);
      check("bg_ack_err", ae_at_done, 0);

      // async reset in the middle of RDATA
      issue(7'h66, 1'b1, 8'h10, 8'h00);
      repeat (350) @(negedge clk);
      check("mr_busy_before", busy, 1);
      rst = 1'b1;
      #1;
      check("mr_scl", scl, 1);
      check("mr_sda", sda, 1);
      check("mr_busy", busy, 0);
      check("mr_done", done, 0);
      check("mr_rdata", rdata, 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      d0 = n_done;
      issue(7'h66, 1'b1, 8'h10, 8'h00);
      wait_done(d0, "ar");
      check("ar_byte0", bus_bytes[0], 8'hCD);
      check("ar_rdata", rd_at_done, 8'hA5);
      check("ar_ack_err", ae_at_done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
